// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving a BCD decoder with lamp-test, blanking
// and latch controls, double-buffered display data and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL      = 1000,
    parameter int unsigned BLANK      = 8,
    parameter int unsigned LT_CYCLES  = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    load,
    output logic                    ready,
    input  logic                    lamp_test,
    input  logic                    lzb_en,
    output logic [3:0]              A,
    output logic                    LT_N,
    output logic                    BI_N,
    output logic                    LE,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int unsigned MaxA   = (LT_CYCLES > DWELL) ? LT_CYCLES : DWELL;
    localparam int unsigned MaxCnt = (MaxA > BLANK) ? MaxA : BLANK;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);
    localparam int unsigned IW     = $clog2(NUM_DIGITS);
    localparam int unsigned DW     = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] LampLast  = CW'(LT_CYCLES - 1);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK - 1);
    localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {Lamp, Blnk, Latch, Show} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            lzb_q, lzb_d;
    logic            wrap_q, wrap_d;
    logic [DW-1:0]   active_q, active_d;
    logic [DW-1:0]   pdata_q, pdata_d;
    logic            pend_q, pend_d;

    logic [3:0]            a_q, a_d;
    logic                  lt_n_q, lt_n_d;
    logic                  bi_n_q, bi_n_d;
    logic                  le_q, le_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q;

    logic [NUM_DIGITS-1:0] zero_above;
    logic [3:0]            nib;
    logic                  accept;

    assign ready      = ~pend_q;
    assign accept     = load & ~pend_q;
    assign A          = a_q;
    assign LT_N       = lt_n_q;
    assign BI_N       = bi_n_q;
    assign LE         = le_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

    // zero_above[i]: nibble i and every more significant nibble are zero.
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (active_q[DW-1 -: 4] == 4'h0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (active_q[4*i +: 4] == 4'h0);
        end
    end

    assign nib = active_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        lzb_d   = lzb_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            Lamp: begin
                if (cnt_q == LampLast) begin
                    state_d = Blnk;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            Blnk: begin
                if (cnt_q == BlankLast) begin
                    state_d = Latch;
                    cnt_d   = '0;
                    lzb_d   = lzb_en;
                end
            end
            Latch: begin
                state_d = Show;
                cnt_d   = '0;
            end
            Show: begin
                if (cnt_q == DwellLast) begin
                    state_d = Blnk;
                    cnt_d   = '0;
                    if (idx_q == IdxLast) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = Lamp;
        endcase
    end

    // A load landing exactly on the wrap goes straight to the active buffer.
    always_comb begin
        active_d = active_q;
        pdata_d  = pdata_q;
        pend_d   = pend_q;
        if (wrap_d) begin
            if (pend_q) begin
                active_d = pdata_q;
                pend_d   = 1'b0;
            end else if (load) begin
                active_d = data;
            end
        end else if (accept) begin
            pdata_d = data;
            pend_d  = 1'b1;
        end
    end

    always_comb begin
        a_d       = nib;
        lt_n_d    = 1'b1;
        bi_n_d    = 1'b0;
        le_d      = 1'b0;
        dig_sel_d = '0;
        unique case (state_q)
            Lamp: begin
                a_d       = 4'h0;
                lt_n_d    = 1'b0;
                bi_n_d    = 1'b1;
                dig_sel_d = '1;
            end
            Latch, Show: begin
                dig_sel_d = NUM_DIGITS'(1) << idx_q;
                lt_n_d    = ~lamp_test;
                bi_n_d    = lamp_test | ~(lzb_q & (idx_q != '0) & zero_above[idx_q]);
                le_d      = (state_q == Show);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= Lamp;
            cnt_q        <= '0;
            idx_q        <= '0;
            lzb_q        <= 1'b0;
            wrap_q       <= 1'b0;
            active_q     <= '0;
            pdata_q      <= '0;
            pend_q       <= 1'b0;
            a_q          <= 4'h0;
            lt_n_q       <= 1'b1;
            bi_n_q       <= 1'b0;
            le_q         <= 1'b0;
            dig_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lzb_q        <= lzb_d;
            wrap_q       <= wrap_d;
            active_q     <= active_d;
            pdata_q      <= pdata_d;
            pend_q       <= pend_d;
            a_q          <= a_d;
            lt_n_q       <= lt_n_d;
            bi_n_q       <= bi_n_d;
            le_q         <= le_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= wrap_q;
        end
    end

endmodule
